// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial WIDTH-bit adder/subtractor with valid/ready handshake
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   input  logic             in_mode,
   input  logic             in_valid,
   output logic             out_ready,
   output logic [WIDTH-1:0] out_D,
   output logic             out_Cout,
   output logic             out_Ovf,
   output logic             out_Zero,
   output logic             out_valid,
   input  logic             in_ready
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] a, b, d_nxt;
   logic [DIGIT-1:0] a_sl, b_sl;
   logic [DIGIT:0]   sum;
   logic [CW-1:0]    cnt;
   logic             mode, carry, c_msb, last;
   always_comb begin
      a_sl = a[int'(cnt)*DIGIT +: DIGIT];
      b_sl = b[int'(cnt)*DIGIT +: DIGIT];
      sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
      // carry into the top bit of this slice; only meaningful on the last slice
      c_msb = sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
      d_nxt = out_D;
      d_nxt[int'(cnt)*DIGIT +: DIGIT] = sum[DIGIT-1:0];
      last = cnt == CW'(N - 1);
   end
   always_comb begin
      state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                  (in_ready ? IDLE : DONE);
      out_ready = state == IDLE;
      out_valid = state == DONE;
   end
   always_ff @(posedge in_clk or posedge in_rst)
      if (in_rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         a <= '0;
         b <= '0;
         mode <= 1'b0;
         carry <= 1'b0;
         cnt <= '0;
         out_D <= '0;
         out_Cout <= 1'b0;
         out_Ovf <= 1'b0;
         out_Zero <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         // subtract is A + ~B + 1
         a <= in_A;
         b <= in_mode ? ~in_B : in_B;
         mode <= in_mode;
         carry <= in_mode;
         cnt <= '0;
      end else if (state == BUSY) begin
         out_D <= d_nxt;
         carry <= sum[DIGIT];
         cnt <= cnt + CW'(1);
         if (last) begin
            out_Cout <= sum[DIGIT] ^ mode;
            out_Ovf <= c_msb ^ sum[DIGIT];
            out_Zero <= d_nxt == '0;
         end
      end
   end
endmodule
